// File: rtl/uart_peripheral_pkg.sv
// Shared definitions for the UART peripheral: register offsets, STATUS bit positions, FSM encodings.
// UART_PARITY_EN adds the PARITY states to both FSM encodings.
package uart_peripheral_pkg;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_RXDATA = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_BAUD   = 2'd3;

  localparam int ST_TX_FULL       = 0;
  localparam int ST_TX_EMPTY      = 1;
  localparam int ST_TX_BUSY       = 2;
  localparam int ST_RX_VALID      = 3;
  localparam int ST_RX_OVERRUN    = 4;
  localparam int ST_RX_FRAME_ERR  = 5;
  localparam int ST_TX_OVERFLOW   = 6;
  localparam int ST_RX_PARITY_ERR = 7;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
`ifdef UART_PARITY_EN
    TX_PARITY = 3'd3,
`endif
    TX_STOP   = 3'd4
  } tx_state_t;

  // RX_BREAK holds off after a framing error until the line returns high.
  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
`ifdef UART_PARITY_EN
    RX_PARITY = 3'd3,
`endif
    RX_STOP   = 3'd4,
    RX_BREAK  = 3'd5
  } rx_state_t;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with wrap-bit pointers; the head entry is visible on dout without a pop.
module uart_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr_reg;
  logic [DEPTH_LOG2:0] rd_ptr_reg;
  logic                push_ok;
  logic                pop_ok;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[DEPTH_LOG2] != rd_ptr_reg[DEPTH_LOG2]) &&
                   (wr_ptr_reg[DEPTH_LOG2-1:0] == rd_ptr_reg[DEPTH_LOG2-1:0]);
  // A push against a full FIFO is dropped even if a pop frees a slot on the same edge.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr_reg[DEPTH_LOG2-1:0]];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg[DEPTH_LOG2-1:0]] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/uart_peripheral.sv
// Memory-mapped UART: TX FIFO + 8N1 serialiser, RX deserialiser with holding register, STATUS and BAUD_DIV.
// Define UART_PARITY_EN for an even-parity bit on TX, checked on RX and reported in STATUS[7].
module uart_peripheral
  import uart_peripheral_pkg::*;
#(
  parameter int CLK_FREQ           = 25000000,
  parameter int BAUD_RATE          = 115200,
  parameter int TX_FIFO_DEPTH_LOG2 = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  input  logic        rx,
  output logic        tx
);

  localparam logic [15:0] BAUD_RESET = 16'(CLK_FREQ / BAUD_RATE);

  logic        wr_txdata, wr_baud, rd_rxdata, rd_status;
  logic [15:0] baud_div_reg;
  logic        fifo_full, fifo_empty, fifo_pop;
  logic [7:0]  fifo_dout;

  tx_state_t   tx_state_reg, tx_state_next;
  logic [15:0] tx_cnt_reg, tx_cnt_next, tx_div_reg, tx_div_next;
  logic [7:0]  tx_shift_reg, tx_shift_next;
  logic [2:0]  tx_bit_reg, tx_bit_next;
  logic        tx_line_reg, tx_line_next, tx_bit_end;

  logic        rx_meta_reg, rx_sync_reg, rx_prev_reg;
  rx_state_t   rx_state_reg, rx_state_next;
  logic [15:0] rx_cnt_reg, rx_cnt_next, rx_div_reg, rx_div_next;
  logic [7:0]  rx_shift_reg, rx_shift_next;
  logic [2:0]  rx_bit_reg, rx_bit_next;
  logic        rx_sample, rx_done, rx_frame_set;
  logic [7:0]  rx_byte_reg;
  logic        rx_valid_reg, rx_overrun_reg, rx_frame_err_reg, tx_overflow_reg;
  logic        parity_flag;
  logic [7:0]  status;
  logic        unused_bits;

  assign wr_txdata   = write && (address[3:2] == REG_TXDATA);
  assign wr_baud     = write && (address[3:2] == REG_BAUD);
  assign rd_rxdata   = read && (address[3:2] == REG_RXDATA);
  assign rd_status   = read && (address[3:2] == REG_STATUS);
  assign unused_bits = ^{address[31:4], address[1:0], write_data[31:16]};

  uart_fifo #(.WIDTH(8), .DEPTH_LOG2(TX_FIFO_DEPTH_LOG2)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_txdata),
    .din   (write_data[7:0]),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // ---------------- TX serialiser ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_reg <= TX_IDLE;
      tx_cnt_reg   <= '0;
      tx_div_reg   <= BAUD_RESET;
      tx_shift_reg <= '0;
      tx_bit_reg   <= '0;
      tx_line_reg  <= 1'b1;
    end else begin
      tx_state_reg <= tx_state_next;
      tx_cnt_reg   <= tx_cnt_next;
      tx_div_reg   <= tx_div_next;
      tx_shift_reg <= tx_shift_next;
      tx_bit_reg   <= tx_bit_next;
      tx_line_reg  <= tx_line_next;
    end
  end

  // The bit period is latched at every bit boundary so BAUD_DIV writes never split a bit.
  always_comb begin
    tx_state_next = tx_state_reg;
    tx_shift_next = tx_shift_reg;
    tx_bit_next   = tx_bit_reg;
    tx_line_next  = tx_line_reg;
    fifo_pop      = 1'b0;
    tx_bit_end    = (tx_cnt_reg == tx_div_reg - 16'd1);
    tx_cnt_next   = tx_bit_end ? 16'd0 : tx_cnt_reg + 16'd1;
    tx_div_next   = tx_bit_end ? baud_div_reg : tx_div_reg;
    case (tx_state_reg)
      TX_IDLE: begin
        tx_cnt_next  = '0;
        tx_div_next  = baud_div_reg;
        tx_line_next = 1'b1;
        if (!fifo_empty) begin
          fifo_pop      = 1'b1;
          tx_shift_next = fifo_dout;
          tx_line_next  = 1'b0;
          tx_state_next = TX_START;
        end
      end
      TX_START: if (tx_bit_end) begin
        tx_state_next = TX_DATA;
        tx_bit_next   = '0;
        tx_line_next  = tx_shift_reg[0];
      end
      TX_DATA: if (tx_bit_end) begin
        // Rotate rather than shift so the byte is intact for the parity bit.
        tx_shift_next = {tx_shift_reg[0], tx_shift_reg[7:1]};
        if (tx_bit_reg == 3'd7) begin
`ifdef UART_PARITY_EN
          tx_state_next = TX_PARITY;
          tx_line_next  = even_parity(tx_shift_reg);
`else
          tx_state_next = TX_STOP;
          tx_line_next  = 1'b1;
`endif
        end else begin
          tx_bit_next  = tx_bit_reg + 3'd1;
          tx_line_next = tx_shift_reg[1];
        end
      end
`ifdef UART_PARITY_EN
      TX_PARITY: if (tx_bit_end) begin
        tx_state_next = TX_STOP;
        tx_line_next  = 1'b1;
      end
`endif
      TX_STOP: if (tx_bit_end) begin
        if (!fifo_empty) begin
          fifo_pop      = 1'b1;
          tx_shift_next = fifo_dout;
          tx_line_next  = 1'b0;
          tx_state_next = TX_START;
        end else begin
          tx_line_next  = 1'b1;
          tx_state_next = TX_IDLE;
        end
      end
      default: begin
        tx_state_next = TX_IDLE;
        tx_line_next  = 1'b1;
      end
    endcase
  end

  assign tx = tx_line_reg;

  // ---------------- RX deserialiser ----------------
`ifdef UART_PARITY_EN
  logic rx_par_bad_reg, rx_par_bad_next, rx_parity_err_reg;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_reg  <= 1'b1;
      rx_sync_reg  <= 1'b1;
      rx_prev_reg  <= 1'b1;
      rx_state_reg <= RX_IDLE;
      rx_cnt_reg   <= '0;
      rx_div_reg   <= BAUD_RESET;
      rx_shift_reg <= '0;
      rx_bit_reg   <= '0;
`ifdef UART_PARITY_EN
      rx_par_bad_reg <= 1'b0;
`endif
    end else begin
      rx_meta_reg  <= rx;
      rx_sync_reg  <= rx_meta_reg;
      rx_prev_reg  <= rx_sync_reg;
      rx_state_reg <= rx_state_next;
      rx_cnt_reg   <= rx_cnt_next;
      rx_div_reg   <= rx_div_next;
      rx_shift_reg <= rx_shift_next;
      rx_bit_reg   <= rx_bit_next;
`ifdef UART_PARITY_EN
      rx_par_bad_reg <= rx_par_bad_next;
`endif
    end
  end

  always_comb begin
    rx_state_next = rx_state_reg;
    rx_shift_next = rx_shift_reg;
    rx_bit_next   = rx_bit_reg;
    rx_done       = 1'b0;
    rx_frame_set  = 1'b0;
`ifdef UART_PARITY_EN
    rx_par_bad_next = rx_par_bad_reg;
`endif
    rx_sample   = (rx_cnt_reg == rx_div_reg - 16'd1);
    rx_cnt_next = rx_sample ? 16'd0 : rx_cnt_reg + 16'd1;
    rx_div_next = rx_sample ? baud_div_reg : rx_div_reg;
    case (rx_state_reg)
      RX_IDLE: begin
        rx_div_next = baud_div_reg;
        // The edge-detect cycle counts as the first cycle of the start bit.
        rx_cnt_next = 16'd1;
        if (rx_prev_reg && !rx_sync_reg) rx_state_next = RX_START;
`ifdef UART_PARITY_EN
        rx_par_bad_next = 1'b0;
`endif
      end
      RX_START: begin
        rx_div_next = rx_div_reg;
        if (rx_cnt_reg >= {1'b0, rx_div_reg[15:1]}) begin
          rx_cnt_next   = '0;
          rx_div_next   = baud_div_reg;
          rx_bit_next   = '0;
          rx_state_next = rx_sync_reg ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: if (rx_sample) begin
        rx_shift_next = {rx_sync_reg, rx_shift_reg[7:1]};
        if (rx_bit_reg == 3'd7) begin
`ifdef UART_PARITY_EN
          rx_state_next = RX_PARITY;
`else
          rx_state_next = RX_STOP;
`endif
        end else begin
          rx_bit_next = rx_bit_reg + 3'd1;
        end
      end
`ifdef UART_PARITY_EN
      RX_PARITY: if (rx_sample) begin
        rx_par_bad_next = rx_sync_reg != even_parity(rx_shift_reg);
        rx_state_next   = RX_STOP;
      end
`endif
      RX_STOP: if (rx_sample) begin
        if (rx_sync_reg) begin
          rx_done       = 1'b1;
          rx_state_next = RX_IDLE;
        end else begin
          rx_frame_set  = 1'b1;
          rx_state_next = RX_BREAK;
        end
      end
      RX_BREAK: if (rx_sync_reg) rx_state_next = RX_IDLE;
      default: rx_state_next = RX_IDLE;
    endcase
  end

  // ---------------- Registers and sticky flags ----------------
  // A flag raised on the same edge as a STATUS read survives; the read only clears older events.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud_div_reg     <= BAUD_RESET;
      rx_byte_reg      <= '0;
      rx_valid_reg     <= 1'b0;
      rx_overrun_reg   <= 1'b0;
      rx_frame_err_reg <= 1'b0;
      tx_overflow_reg  <= 1'b0;
`ifdef UART_PARITY_EN
      rx_parity_err_reg <= 1'b0;
`endif
    end else begin
      if (wr_baud && (write_data[15:0] != 16'd0)) baud_div_reg <= write_data[15:0];
      if (rx_done) begin
        rx_byte_reg  <= rx_shift_reg;
        rx_valid_reg <= 1'b1;
      end else if (rd_rxdata) begin
        rx_valid_reg <= 1'b0;
      end
      if (rx_done && rx_valid_reg && !rd_rxdata) rx_overrun_reg <= 1'b1;
      else if (rd_status)                        rx_overrun_reg <= 1'b0;
      if (rx_frame_set)   rx_frame_err_reg <= 1'b1;
      else if (rd_status) rx_frame_err_reg <= 1'b0;
      if (wr_txdata && fifo_full) tx_overflow_reg <= 1'b1;
      else if (rd_status)         tx_overflow_reg <= 1'b0;
`ifdef UART_PARITY_EN
      if (rx_done && rx_par_bad_reg) rx_parity_err_reg <= 1'b1;
      else if (rd_status)            rx_parity_err_reg <= 1'b0;
`endif
    end
  end

`ifdef UART_PARITY_EN
  assign parity_flag = rx_parity_err_reg;
`else
  assign parity_flag = 1'b0;
`endif

  always_comb begin
    status                   = '0;
    status[ST_TX_FULL]       = fifo_full;
    status[ST_TX_EMPTY]      = fifo_empty;
    status[ST_TX_BUSY]       = (tx_state_reg != TX_IDLE);
    status[ST_RX_VALID]      = rx_valid_reg;
    status[ST_RX_OVERRUN]    = rx_overrun_reg;
    status[ST_RX_FRAME_ERR]  = rx_frame_err_reg;
    status[ST_TX_OVERFLOW]   = tx_overflow_reg;
    status[ST_RX_PARITY_ERR] = parity_flag;
  end

  always_comb begin
    read_data = '0;
    case (address[3:2])
      REG_RXDATA: read_data = {24'd0, rx_byte_reg};
      REG_STATUS: read_data = {24'd0, status};
      REG_BAUD:   read_data = {16'd0, baud_div_reg};
      default:    read_data = '0;
    endcase
  end

endmodule
